// File: rtl/echo_mixer.sv
// echo_mixer: mix stage after the echo delay-line FIFO.
// Computes wet = dry + mix_gain*delayed and feedback = dry + fb_gain*delayed
// with one shared multiplier, sequenced IDLE -> MUL_MIX -> MUL_FB -> OUT.
// Handshake: vld_i is a single-cycle strobe accepted only in IDLE (busy_o = 0);
// vld_o / fb_vld_o are one-cycle pulses in OUT, with data_o / fb_data_o stable
// during the pulse and held afterwards. A strobe arriving while busy is dropped
// and latches the sticky ovf_o flag.
// Optional feature macro: ECHO_MIXER_SAT_CNT_EN adds the sat_cnt_o counter.
module echo_mixer #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] dry_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] del_i,
  input  logic [GAIN_WIDTH-1:0] mix_gain,
  input  logic [GAIN_WIDTH-1:0] fb_gain,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] fb_data_o,
  output logic                  fb_vld_o,
  output logic                  busy_o,
  output logic                  ovf_o
`ifdef ECHO_MIXER_SAT_CNT_EN
  ,
  output logic [15:0]           sat_cnt_o
`endif
);

  // product width: signed sample times zero-extended (signed) gain
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  // sum width: one guard bit above the sample width
  localparam int SW = DATA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_MIX = 2'd1,
    MUL_FB  = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t state, state_nxt;

  // sample captured at accept; gains and en hold for the whole sample
  logic [DATA_WIDTH-1:0] dry_r;
  logic [DATA_WIDTH-1:0] del_r;
  logic [GAIN_WIDTH-1:0] mix_gain_r;
  logic [GAIN_WIDTH-1:0] fb_gain_r;
  logic                  en_r;
  logic [DATA_WIDTH-1:0] mix_res_r;
  logic                  ovf_r;

  // shared arithmetic path
  logic [GAIN_WIDTH-1:0] mul_gain;
  logic [GAIN_WIDTH:0]   mul_b;
  logic signed [PW-1:0]  op_a;
  logic signed [PW-1:0]  op_b;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic signed [SW-1:0]  sum;
  logic [DATA_WIDTH-1:0] sat_val;
  logic                  sat_flag;

`ifdef ECHO_MIXER_SAT_CNT_EN
  logic                  mix_sat_r;
  logic                  fb_sat_r;
  logic [15:0]           sat_cnt_r;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and strobe outputs
  always_comb begin
    state_nxt = state;
    vld_o     = 1'b0;
    fb_vld_o  = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE:    if (vld_i) state_nxt = MUL_MIX;
      MUL_MIX: state_nxt = MUL_FB;
      MUL_FB:  state_nxt = OUT;
      OUT: begin
        state_nxt = IDLE;
        vld_o     = 1'b1;
        fb_vld_o  = en_r;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shared multiply, floor shift, widened add and saturation
  always_comb begin
    mul_gain = (state == MUL_FB) ? fb_gain_r : mix_gain_r;
    // bypass forces the wet term to zero so the mix result equals dry
    mul_b    = en_r ? {1'b0, mul_gain} : '0;
    op_a     = {{(PW-DATA_WIDTH){del_r[DATA_WIDTH-1]}}, del_r};
    op_b     = {{(PW-GAIN_WIDTH-1){1'b0}}, mul_b};
    prod     = op_a * op_b;
    shifted  = prod >>> GAIN_WIDTH;
    // the scaled term always fits in DATA_WIDTH bits, so SW bits are exact
    sum      = $signed({dry_r[DATA_WIDTH-1], dry_r}) + shifted[SW-1:0];
    sat_flag = (sum[SW-1] != sum[SW-2]);
    if (sat_flag) sat_val = sum[SW-1] ? MIN_VAL : MAX_VAL;
    else          sat_val = sum[DATA_WIDTH-1:0];
  end

  // datapath registers, output holding registers and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dry_r      <= '0;
      del_r      <= '0;
      mix_gain_r <= '0;
      fb_gain_r  <= '0;
      en_r       <= 1'b0;
      mix_res_r  <= '0;
      data_o     <= '0;
      fb_data_o  <= '0;
      ovf_r      <= 1'b0;
    end else begin
      if (vld_i && state != IDLE) ovf_r <= 1'b1;
      case (state)
        IDLE: begin
          if (vld_i) begin
            dry_r      <= dry_i;
            del_r      <= del_i;
            mix_gain_r <= mix_gain;
            fb_gain_r  <= fb_gain;
            en_r       <= en;
          end
        end
        MUL_MIX: mix_res_r <= sat_val;
        MUL_FB: begin
          data_o    <= mix_res_r;
          fb_data_o <= en_r ? sat_val : '0;
        end
        default: ;
      endcase
    end
  end

  assign ovf_o = ovf_r;

`ifdef ECHO_MIXER_SAT_CNT_EN
  // saturation event counter, one count per sample that clipped
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_sat_r <= 1'b0;
      fb_sat_r  <= 1'b0;
      sat_cnt_r <= '0;
    end else begin
      if (state == MUL_MIX) mix_sat_r <= sat_flag;
      if (state == MUL_FB)  fb_sat_r  <= en_r & sat_flag;
      if (state == OUT && (mix_sat_r || fb_sat_r) && sat_cnt_r != 16'hFFFF)
        sat_cnt_r <= sat_cnt_r + 16'd1;
    end
  end

  assign sat_cnt_o = sat_cnt_r;
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// tb_echo_mixer: directed and randomized checks of echo_mixer against an
// arithmetic reference model (integer multiply, floor divide, clamp).
module tb_echo_mixer;

  localparam int DW = 16;
  localparam int GW = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] dry_i;
  logic          vld_i;
  logic [DW-1:0] del_i;
  logic [GW-1:0] mix_gain;
  logic [GW-1:0] fb_gain;
  logic [DW-1:0] data_o;
  logic          vld_o;
  logic [DW-1:0] fb_data_o;
  logic          fb_vld_o;
  logic          busy_o;
  logic          ovf_o;
`ifdef ECHO_MIXER_SAT_CNT_EN
  logic [15:0]   sat_cnt_o;
`endif

  always #5 clk = ~clk;

  echo_mixer #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dry_i     (dry_i),
    .vld_i     (vld_i),
    .del_i     (del_i),
    .mix_gain  (mix_gain),
    .fb_gain   (fb_gain),
    .data_o    (data_o),
    .vld_o     (vld_o),
    .fb_data_o (fb_data_o),
    .fb_vld_o  (fb_vld_o),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o)
`ifdef ECHO_MIXER_SAT_CNT_EN
    ,
    .sat_cnt_o (sat_cnt_o)
`endif
  );

  // scoreboard
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_fb_q[$];
  int            exp_sat  = 0;

  // reference: dry + floor(del*g/256), clamped to the signed sample range
  function automatic int ref_mix(input int dry, input int del, input int g, output bit sat);
    int prod;
    int q;
    int s;
    prod = del * g;
    q    = prod / 256;
    if (prod < 0 && (prod % 256) != 0) q = q - 1;
    s   = dry + q;
    sat = 1'b0;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    dry_i    = DW'($urandom);
    del_i    = DW'($urandom);
    mix_gain = GW'($urandom);
    fb_gain  = GW'($urandom);
    en       = 1'($urandom);
  endtask

  // driver: one sample, checked across its full 4-cycle slot
  task automatic send(input int dry, input int del, input int mg, input int fg, input bit e);
    int d;
    int f;
    bit s1;
    bit s2;
    logic [DW-1:0] ed;
    logic [DW-1:0] ef;
    if (e) begin
      d = ref_mix(dry, del, mg, s1);
      f = ref_mix(dry, del, fg, s2);
    end else begin
      d = dry; f = 0; s1 = 1'b0; s2 = 1'b0;
    end
    exp_q.push_back(d[DW-1:0]);
    exp_fb_q.push_back(f[DW-1:0]);
    if ((s1 || s2) && exp_sat < 65535) exp_sat++;
    dry_i = dry[DW-1:0]; del_i = del[DW-1:0];
    mix_gain = mg[GW-1:0]; fb_gain = fg[GW-1:0]; en = e; vld_i = 1'b1;
    step();
    vld_i = 1'b0;
    scramble_inputs();
    chk("busy_n1", {31'b0, busy_o}, 32'd1);
    chk("vld_n1", {31'b0, vld_o}, 32'd0);
    step();
    chk("vld_n2", {31'b0, vld_o}, 32'd0);
    step();
    ed = exp_q.pop_front();
    ef = exp_fb_q.pop_front();
    chk("vld_n3", {31'b0, vld_o}, 32'd1);
    chk("fb_vld_n3", {31'b0, fb_vld_o}, {31'b0, e});
    chk("data_n3", {16'b0, data_o}, {16'b0, ed});
    chk("fb_data_n3", {16'b0, fb_data_o}, {16'b0, ef});
    step();
    chk("vld_n4", {31'b0, vld_o}, 32'd0);
    chk("fb_vld_n4", {31'b0, fb_vld_o}, 32'd0);
    chk("busy_n4", {31'b0, busy_o}, 32'd0);
    chk("data_hold", {16'b0, data_o}, {16'b0, ed});
`ifdef ECHO_MIXER_SAT_CNT_EN
    chk("sat_cnt", {16'b0, sat_cnt_o}, exp_sat);
`endif
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_data"}, {16'b0, data_o}, 32'd0);
    chk({tag, "_fb_data"}, {16'b0, fb_data_o}, 32'd0);
    chk({tag, "_vld"}, {31'b0, vld_o}, 32'd0);
    chk({tag, "_fb_vld"}, {31'b0, fb_vld_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ovf_o}, 32'd0);
`ifdef ECHO_MIXER_SAT_CNT_EN
    chk({tag, "_sat_cnt"}, {16'b0, sat_cnt_o}, 32'd0);
`endif
  endtask

  initial begin
    logic signed [DW-1:0] r16;
    int rd;
    int rl;
    rst = 1'b1; vld_i = 1'b0; en = 1'b0;
    dry_i = '0; del_i = '0; mix_gain = '0; fb_gain = '0;
    step(); step(); step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();

    // basic mix
    send(1000, 2000, 128, 64, 1'b1);
    chk("t1_data", {16'b0, data_o}, 32'd2000);
    chk("t1_fb", {16'b0, fb_data_o}, 32'd1500);

    // saturation both directions
    send(30000, 30000, 255, 255, 1'b1);
    chk("t2_pos_data", {16'b0, data_o}, 32'h7FFF);
    chk("t2_pos_fb", {16'b0, fb_data_o}, 32'h7FFF);
    send(-30000, -30000, 255, 255, 1'b1);
    chk("t2_neg_data", {16'b0, data_o}, 32'h8000);
    chk("t2_neg_fb", {16'b0, fb_data_o}, 32'h8000);

    // floor rounding
    send(0, -1, 128, 0, 1'b1);
    chk("t3_neg", {16'b0, data_o}, 32'hFFFF);
    send(0, 1, 128, 0, 1'b1);
    chk("t3_pos", {16'b0, data_o}, 32'd0);

    // bypass
    send(500, 7000, 200, 200, 1'b0);
    chk("t5_data", {16'b0, data_o}, 32'd500);
    chk("t5_fb", {16'b0, fb_data_o}, 32'd0);

    // randomized samples with random idle gaps
    for (int i = 0; i < 40; i++) begin
      r16 = DW'($urandom);
      rd  = r16;
      r16 = DW'($urandom);
      rl  = r16;
      send(rd, rl, $urandom_range(0, 255), $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
    end
    chk("no_ovf_yet", {31'b0, ovf_o}, 32'd0);

    // overrun: strobe at cycle 0 and again at cycle 2
    dry_i = 16'd1234; del_i = 16'd100; mix_gain = 8'd128; fb_gain = 8'd128; en = 1'b1;
    vld_i = 1'b1;
    step();
    vld_i = 1'b0;
    step();
    dry_i = 16'd4321; vld_i = 1'b1;
    step();
    vld_i = 1'b0;
    chk("ovr_vld_n3", {31'b0, vld_o}, 32'd1);
    chk("ovr_data", {16'b0, data_o}, 32'd1284);
    chk("ovr_fb", {16'b0, fb_data_o}, 32'd1284);
    chk("ovr_flag", {31'b0, ovf_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ovr_no_second", {31'b0, vld_o}, 32'd0);
      chk("ovr_idle", {31'b0, busy_o}, 32'd0);
    end
    chk("ovr_sticky", {31'b0, ovf_o}, 32'd1);

    // reset in the middle of a sample
    dry_i = 16'd777; del_i = 16'd333; mix_gain = 8'd100; fb_gain = 8'd50; en = 1'b1;
    vld_i = 1'b1;
    step();
    vld_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sat = 0;
    check_idle_zero("midrst");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst_no_vld", {30'b0, vld_o, fb_vld_o}, 32'd0);
    end

    // recovery after reset
    send(-1234, 5678, 77, 199, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
